btn_msg_sequencer: RTL
======================

Name: btn_msg_sequencer

Overview:
- Sits upstream of a byte-level UART serializer and feeds it.
- Detects debounced button press edges and queues one message per press.
- Streams the ASCII message "Button <n> Pressed!\r\n" (19 bytes) over a valid/ready byte interface.
- This separates message generation from serialization, so the UART transmitter becomes a plain byte sink.

Parameters:
- BUTTON_WIDTH, 2, number of buttons; legal range 1..10 (digit n is a single decimal character '0'..'9').
- BUTTON_POLARITY_VECTOR, 2'b11, per-button polarity; 1 = pressed when high, 0 = pressed when low.

Ports:
- clk  input  1  system clock (12 MHz in the Cmod S7 design).
- rst  input  1  reset, asynchronous, active-high.
- btn  input  BUTTON_WIDTH  debounced button levels, synchronous to clk.
- m_data  output  8  ASCII byte to the serializer.
- m_valid  output  1  m_data is valid.
- m_ready  input  1  serializer accepts the byte this cycle.
- busy  output  1  high while any message is pending or being sent.

Behaviour:
- The single clock is clk. Reset rst is asynchronous and active-high.
- Normalization: pressed[i] = btn[i] XNOR BUTTON_POLARITY_VECTOR[i].
- prev register:
  - Holds pressed from the previous cycle.
  - Resets to all-ones, so a button held through reset does not fire.
- Press edge: pressed[i] & ~prev[i], evaluated at each rising clk edge.
- pending[BUTTON_WIDTH-1:0]:
  - A press edge at edge k sets pending[i] at edge k.
  - Max one queued message per button; further presses while pending is already set are dropped.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- FSM states:
  - IDLE:
    - If pending != 0, select the lowest-index set bit, store it as sel, clear that bit, set char_idx = 0, go to SEND.
    - Otherwise stay in IDLE.
  - SEND:
    - m_valid = 1.
    - On m_valid & m_ready: if char_idx == 18, go to IDLE; else char_idx += 1.
    - Without m_ready, hold state, char_idx and sel.
- Byte map by char_idx:
  - 0..6: "Button "
  - 7: ASCII '0' + sel
  - 8..16: " Pressed!"
  - 17: 0x0D
  - 18: 0x0A
- m_data:
  - Decoded from registered sel and char_idx only, with no combinational path from m_ready.
  - Must stay stable while m_valid & ~m_ready.
  - Outside SEND, m_data = 0x00.
- Latency:
  - Press edge sampled at edge k, FSM in IDLE: m_valid is high after edge k+1.
  - Back-to-back messages have exactly one IDLE cycle between the final accepted 0x0A and the next m_valid.
- m_valid may not drop without a handshake, except on reset.
- busy = (state != IDLE) | (|pending); it is combinational from registers.
- Widths: char_idx is 5 bits; sel is ceil(log2(BUTTON_WIDTH)) bits, minimum 1.
- Reset values:
  - state = IDLE, pending = 0, prev = all-ones, char_idx = 0, sel = 0.
  - m_valid = 0, m_data = 0x00, busy = 0.
- Reset mid-message: the message is truncated immediately, m_valid falls asynchronously, and no resume occurs after reset.
- Simultaneous presses of buttons 0 and 1 in the same cycle: both are queued; button 0 is sent first, then button 1.

Test Plan:
- Reset with btn = 2'b11 held, then release and wait -> no m_valid; busy = 0.
- Press btn[0] (rising edge at edge k), m_ready tied 1 -> m_valid high after edge k+1; 19 consecutive bytes 42 75 74 74 6F 6E 20 30 20 50 72 65 73 73 65 64 21 0D 0A; then m_valid = 0 and busy = 0.
- Press btn[0] and btn[1] in the same cycle, m_ready = 1 -> "Button 0 Pressed!\r\n", one idle cycle, then "Button 1 Pressed!\r\n".
- Random m_ready backpressure (~50%) during one message -> m_data stable whenever m_valid & ~m_ready; byte sequence identical to scenario 2; no bytes dropped or duplicated.
- During a message, press btn[1] three times -> exactly one "Button 1" message follows; btn[0] pressed again mid-message -> its second message is queued once.
- Assert rst at char_idx = 9 -> m_valid = 0 in the same cycle (asynchronous); after release, a new btn[1] press sends a complete message starting at 0x42.
- With BUTTON_POLARITY_VECTOR = 2'b01, btn[1] falling edge -> message with digit 0x31.

Source files
------------

// File: rtl/btn_msg_sequencer.sv
// btn_msg_sequencer: turns debounced button press edges into queued ASCII
// messages "Button <n> Pressed!\r\n" streamed over a valid/ready byte interface.
module btn_msg_sequencer #(
    parameter int unsigned                BUTTON_WIDTH           = 2,
    parameter logic [BUTTON_WIDTH-1:0]    BUTTON_POLARITY_VECTOR = {BUTTON_WIDTH{1'b1}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUTTON_WIDTH-1:0] btn,
    output logic [7:0]              m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    busy
);

    localparam int unsigned SEL_W    = (BUTTON_WIDTH > 1) ? $clog2(BUTTON_WIDTH) : 1;
    localparam int unsigned IDX_W    = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(18);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                  r_state;
    logic [SEL_W-1:0]        r_sel;
    logic [IDX_W-1:0]        r_char_idx;
    logic [BUTTON_WIDTH-1:0] r_pending;
    logic [BUTTON_WIDTH-1:0] r_prev;
    logic                    r_valid;

    logic [BUTTON_WIDTH-1:0] w_pressed;
    logic [BUTTON_WIDTH-1:0] w_edge;
    logic [BUTTON_WIDTH-1:0] w_lowest;
    logic [BUTTON_WIDTH-1:0] w_clr;
    logic [SEL_W-1:0]        w_first;
    logic [7:0]              w_data;

    // Normalize polarity, detect press edges, isolate the lowest pending bit
    assign w_pressed = ~(btn ^ BUTTON_POLARITY_VECTOR);
    assign w_edge    = w_pressed & ~r_prev;
    assign w_lowest  = r_pending & (~r_pending + BUTTON_WIDTH'(1));
    assign w_clr     = (r_state == S_IDLE) ? w_lowest : '0;

    // Index of the lowest set pending bit (lowest index has priority)
    always_comb begin
        w_first = '0;
        for (int i = int'(BUTTON_WIDTH) - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_first = SEL_W'(i);
            end
        end
    end

    // Edge history, pending queue and message FSM; a new press beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_char_idx <= '0;
            r_pending  <= '0;
            r_prev     <= '1;
            r_valid    <= 1'b0;
        end else begin
            r_prev    <= w_pressed;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            case (r_state)
                S_IDLE: begin
                    if (|r_pending) begin
                        r_sel      <= w_first;
                        r_char_idx <= '0;
                        r_state    <= S_SEND;
                        r_valid    <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (m_ready) begin
                        if (r_char_idx == LAST_IDX) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                        end else begin
                            r_char_idx <= r_char_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Byte decode from registered sel/char_idx only, so it holds steady under backpressure
    always_comb begin
        w_data = 8'h00;
        if (r_state == S_SEND) begin
            case (r_char_idx)
                5'd0:    w_data = 8'h42; // B
                5'd1:    w_data = 8'h75; // u
                5'd2:    w_data = 8'h74; // t
                5'd3:    w_data = 8'h74; // t
                5'd4:    w_data = 8'h6F; // o
                5'd5:    w_data = 8'h6E; // n
                5'd6:    w_data = 8'h20; // space
                5'd7:    w_data = 8'h30 + 8'(r_sel);
                5'd8:    w_data = 8'h20; // space
                5'd9:    w_data = 8'h50; // P
                5'd10:   w_data = 8'h72; // r
                5'd11:   w_data = 8'h65; // e
                5'd12:   w_data = 8'h73; // s
                5'd13:   w_data = 8'h73; // s
                5'd14:   w_data = 8'h65; // e
                5'd15:   w_data = 8'h64; // d
                5'd16:   w_data = 8'h21; // !
                5'd17:   w_data = 8'h0D; // CR
                5'd18:   w_data = 8'h0A; // LF
                default: w_data = 8'h00;
            endcase
        end
    end

    assign m_data  = w_data;
    assign m_valid = r_valid;
    assign busy    = (r_state != S_IDLE) | (|r_pending);

endmodule
